tmr_err_monitor: RTL and testbench
==================================

TMR_ERR_MONITOR -- requirements
Module: tmr_err_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the saturating mismatch counter.
REQ-002 Parameter THRESH, default 4: consecutive err_in cycles that declare FAULT; legal range 2..255.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port err_in  input  1  mismatch flag from the upstream triplicated design's error sink; synchronous to clk.
REQ-006 Port clr  input  1  software clear of sticky flags and counter.
REQ-007 Port resync_ack  input  1  voter re-sync complete acknowledgement.
REQ-008 Port err_count  output  CNT_W  saturating count of cycles with err_in=1.
REQ-009 Port state  output  2  current FSM state encoding.
REQ-010 Port fault  output  1  sticky FAULT flag.
REQ-011 Port irq  output  1  level interrupt, set on any mismatch, held until clr.
REQ-012 Port resync_req  output  1  re-sync request to the voter, req/ack handshake.

Function
REQ-013 All outputs are registered; err_in sampled at edge N affects outputs visible after edge N (one-cycle latency).
REQ-014 FSM states: OK=0, TRANSIENT=1, FAULT=2, RESYNC=3.
REQ-015 OK: err_in=1 -> TRANSIENT, run counter loaded with 1; otherwise stay.
REQ-016 TRANSIENT: err_in=1 increments the run counter; when it reaches THRESH -> FAULT; err_in=0 -> OK, run counter cleared.
REQ-017 FAULT: lasts exactly one cycle, sets fault=1, asserts resync_req, then -> RESYNC.
REQ-018 RESYNC: resync_req stays 1 until resync_ack=1 is sampled; on that edge resync_req drops and state -> OK, run counter cleared.
REQ-019 resync_ack while resync_req=0 is ignored.
REQ-020 err_in is ignored by the FSM in FAULT and RESYNC but still increments err_count.
REQ-021 err_count increments by 1 on every edge with err_in=1 and saturates at 2^CNT_W-1 without wrapping.
REQ-022 irq sets on the first edge with err_in=1 and stays 1 until cleared.
REQ-023 clr=1 clears err_count, irq and fault on that edge; it does not change state, the run counter or resync_req.
REQ-024 clr and err_in both 1 on the same edge: clear wins; after the edge err_count=1 and irq=1.
REQ-025 clr while in FAULT: fault is 0 after the edge; the FSM still goes to RESYNC.

Reset
REQ-026 rst=1 forces, asynchronously: state=OK, run counter=0, err_count=0, irq=0, fault=0, resync_req=0.
REQ-027 rst asserted mid-handshake abandons the request; resync_req=0 while rst is high.
REQ-028 The first sampling edge is the first posedge clk after rst deasserts.

Structure
REQ-029 A shared package tamara_mon_pkg holds the state enum (OK/TRANSIENT/FAULT/RESYNC) and the default parameter constants.
REQ-030 One sub-module, sat_counter (parameterised width, inc, clr, saturating), implements err_count; the run counter is inline.
REQ-031 The block carries no TMR attributes itself; it is the non-triplicated consumer of a triplicated design's error sink.

Verification
REQ-032 Reset, then err_in=1 for 1 cycle, then 0: state OK->TRANSIENT->OK; err_count=1; irq=1; fault=0.
REQ-033 err_in=1 for 4 cycles, THRESH=4: FAULT one cycle after the 4th sample, then RESYNC with resync_req=1; resync_ack pulse after 3 cycles -> resync_req=0, state=OK, fault still 1.
REQ-034 CNT_W=3, err_in=1 for 10 cycles: err_count saturates at 7 and stays 7.
REQ-035 clr and err_in both 1 on the same edge with err_count=5: err_count=1 and irq=1 afterwards.
REQ-036 rst asserted during RESYNC with no ack: resync_req, fault and irq are 0 immediately, before any clk edge; state=OK.
REQ-037 resync_ack=1 while in OK: no state or output change.

Source files
------------

// File: rtl/tamara_mon_pkg.sv
// Shared types and default parameters for the TMR error monitor.
package tamara_mon_pkg;

    // The encoding is visible on the state port, so the values are fixed.
    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_TRANSIENT = 2'd1,
        ST_FAULT     = 2'd2,
        ST_RESYNC    = 2'd3
    } mon_state_e;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_THRESH = 4;

    // Wide enough to hold the largest legal THRESH (255).
    localparam int RUN_W = 8;

endpackage : tamara_mon_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority but
// still counts an increment arriving on the same edge.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/tmr_err_monitor.sv
// Non-triplicated consumer of a TMR error sink: counts mismatches, separates
// transient from persistent faults and drives the voter re-sync handshake.
module tmr_err_monitor
    import tamara_mon_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int THRESH = DEF_THRESH   // legal range 2..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_in,
    input  logic             clr,
    input  logic             resync_ack,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state,
    output logic             fault,
    output logic             irq,
    output logic             resync_req
);

    localparam logic [RUN_W-1:0] THRESH_RUN = RUN_W'(THRESH);

    mon_state_e       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_inc;
    logic             fault_q, fault_d;
    logic             irq_q, irq_d;
    logic             req_q, req_d;

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (err_in),
        .clr_i   (clr),
        .count_o (err_count)
    );

    assign run_inc = run_q + RUN_W'(1);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        req_d   = req_q;
        // Clear is applied first, then this edge's events, so a new mismatch survives a clear.
        fault_d = clr ? 1'b0 : fault_q;
        irq_d   = (clr ? 1'b0 : irq_q) | err_in;

        unique case (state_q)
            ST_OK: begin
                if (err_in) begin
                    state_d = ST_TRANSIENT;
                    run_d   = RUN_W'(1);
                end
            end
            ST_TRANSIENT: begin
                if (err_in) begin
                    run_d = run_inc;
                    if (run_inc == THRESH_RUN) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        req_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_OK;
                    run_d   = '0;
                end
            end
            // Single-cycle marker; err_in and resync_ack are ignored here.
            ST_FAULT: begin
                state_d = ST_RESYNC;
            end
            ST_RESYNC: begin
                if (resync_ack) begin
                    state_d = ST_OK;
                    req_d   = 1'b0;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ST_OK;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OK;
            run_q   <= '0;
            fault_q <= 1'b0;
            irq_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            fault_q <= fault_d;
            irq_q   <= irq_d;
            req_q   <= req_d;
        end
    end

    assign state      = state_q;
    assign fault      = fault_q;
    assign irq        = irq_q;
    assign resync_req = req_q;

endmodule : tmr_err_monitor

// File: tb/tb_tmr_err_monitor.sv
// Bench for tmr_err_monitor: two instances (8-bit/THRESH 4 and 3-bit/THRESH 2)
// share stimulus and are checked every cycle against a behavioural model.
module tb_tmr_err_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_in = 1'b0;
    logic clr = 1'b0;
    logic resync_ack = 1'b0;

    logic [7:0] cnt_a;
    logic [2:0] cnt_b;
    logic [1:0] st_a, st_b;
    logic       fault_a, fault_b, irq_a, irq_b, req_a, req_b;

    always #5 clk = ~clk;

    tmr_err_monitor #(.CNT_W(8), .THRESH(4)) dut_a (
        .clk(clk), .rst(rst), .err_in(err_in), .clr(clr), .resync_ack(resync_ack),
        .err_count(cnt_a), .state(st_a), .fault(fault_a), .irq(irq_a), .resync_req(req_a)
    );

    tmr_err_monitor #(.CNT_W(3), .THRESH(2)) dut_b (
        .clk(clk), .rst(rst), .err_in(err_in), .clr(clr), .resync_ack(resync_ack),
        .err_count(cnt_b), .state(st_b), .fault(fault_b), .irq(irq_b), .resync_req(req_b)
    );

    // Model: errs = mismatches seen since the last clear/reset (unbounded);
    // count and irq are derived from it, st follows the spec's state numbering.
    typedef struct {
        int st;
        int run;
        int errs;
        bit fault;
        bit req;
    } mdl_t;

    mdl_t ma, mb;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = 0; m.run = 0; m.errs = 0; m.fault = 1'b0; m.req = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit e, bit c, bit a, int thresh);
        mdl_t n = m;
        if (c) begin
            n.errs  = 0;
            n.fault = 1'b0;
        end
        if (e) n.errs = n.errs + 1;
        case (m.st)
            0: if (e) begin n.st = 1; n.run = 1; end
            1: begin
                if (!e) begin
                    n.st = 0; n.run = 0;
                end else begin
                    n.run = m.run + 1;
                    if (n.run >= thresh) begin
                        n.st = 2; n.fault = 1'b1; n.req = 1'b1;
                    end
                end
            end
            2: n.st = 3;
            default: if (a) begin n.st = 0; n.req = 1'b0; n.run = 0; end
        endcase
        return n;
    endfunction

    function automatic int cap(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, err_in, clr, resync_ack, 4);
            mb <= mdl_step(mb, err_in, clr, resync_ack, 2);
        end
    end

    always @(negedge clk) begin
        check("a_state", 32'(st_a), 32'(ma.st));
        check("a_count", 32'(cnt_a), 32'(cap(ma.errs, 255)));
        check("a_irq", 32'(irq_a), 32'(ma.errs > 0));
        check("a_fault", 32'(fault_a), 32'(ma.fault));
        check("a_req", 32'(req_a), 32'(ma.req));
        check("b_state", 32'(st_b), 32'(mb.st));
        check("b_count", 32'(cnt_b), 32'(cap(mb.errs, 7)));
        check("b_irq", 32'(irq_b), 32'(mb.errs > 0));
        check("b_fault", 32'(fault_b), 32'(mb.fault));
        check("b_req", 32'(req_b), 32'(mb.req));
    end

    // Drive inputs 2 time units after an edge, let the next edge sample them,
    // and return 2 units after that edge with the registered results visible.
    task automatic cyc(input bit e, input bit c, input bit a);
        err_in = e; clr = c; resync_ack = a;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", 32'(st_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_irq", 32'(irq_a), 32'd0);
        check("rst_fault", 32'(fault_a), 32'd0);
        check("rst_req", 32'(req_a), 32'd0);
        rst = 1'b0;

        // Single mismatch: OK -> TRANSIENT -> OK.
        cyc(1, 0, 0);
        check("single_state", 32'(st_a), 32'd1);
        check("single_count", 32'(cnt_a), 32'd1);
        check("single_irq", 32'(irq_a), 32'd1);
        cyc(0, 0, 0);
        check("single_back_ok", 32'(st_a), 32'd0);
        check("single_no_fault", 32'(fault_a), 32'd0);

        // Four consecutive mismatches reach THRESH=4.
        repeat (3) cyc(1, 0, 0);
        check("run3_state", 32'(st_a), 32'd1);
        cyc(1, 0, 0);
        check("fault_state", 32'(st_a), 32'd2);
        check("fault_flag", 32'(fault_a), 32'd1);
        check("fault_req", 32'(req_a), 32'd1);
        check("fault_count", 32'(cnt_a), 32'd5);
        check("model_a_errs", 32'(ma.errs), 32'd5);
        cyc(0, 0, 0);
        check("resync_state", 32'(st_a), 32'd3);
        check("resync_req", 32'(req_a), 32'd1);
        repeat (2) cyc(0, 0, 0);
        check("resync_hold", 32'(req_a), 32'd1);
        cyc(0, 0, 1);
        check("ack_state", 32'(st_a), 32'd0);
        check("ack_req", 32'(req_a), 32'd0);
        check("ack_fault_sticky", 32'(fault_a), 32'd1);

        // Ack while idle is ignored.
        cyc(0, 0, 1);
        check("idle_ack_state", 32'(st_a), 32'd0);
        check("idle_ack_req", 32'(req_a), 32'd0);
        check("idle_ack_count", 32'(cnt_a), 32'd5);

        // Clear and mismatch on the same edge with count 5.
        cyc(1, 1, 0);
        check("clr_err_count", 32'(cnt_a), 32'd1);
        check("clr_err_irq", 32'(irq_a), 32'd1);
        check("clr_err_fault", 32'(fault_a), 32'd0);
        check("model_a_after_clr", 32'(ma.errs), 32'd1);
        cyc(0, 0, 0);

        // Saturation of the 3-bit counter.
        cyc(0, 1, 0);
        check("clr_only_count", 32'(cnt_a), 32'd0);
        check("clr_only_irq", 32'(irq_a), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 0);
            check("sat_b_count", 32'(cnt_b), 32'(cap(k, 7)));
        end
        check("sat_a_count", 32'(cnt_a), 32'd10);
        check("sat_a_state", 32'(st_a), 32'd3);

        // Clear while in FAULT: flag drops, FSM still proceeds to RESYNC.
        cyc(0, 0, 1);
        repeat (4) cyc(1, 0, 0);
        check("fault2_state", 32'(st_a), 32'd2);
        cyc(0, 1, 0);
        check("clr_in_fault_flag", 32'(fault_a), 32'd0);
        check("clr_in_fault_state", 32'(st_a), 32'd3);
        check("clr_in_fault_req", 32'(req_a), 32'd1);

        // Reset mid-handshake takes effect without a clock edge.
        cyc(0, 0, 1);
        repeat (4) cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("pre_rst_req", 32'(req_a), 32'd1);
        check("pre_rst_irq", 32'(irq_a), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_req", 32'(req_a), 32'd0);
        check("async_rst_fault", 32'(fault_a), 32'd0);
        check("async_rst_irq", 32'(irq_a), 32'd0);
        check("async_rst_state", 32'(st_a), 32'd0);
        check("async_rst_b_req", 32'(req_b), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Randomised phase with bursty error density.
        for (int seg = 0; seg < 30; seg++) begin
            int bias;
            case ($urandom_range(0, 2))
                0:       bias = 15;
                1:       bias = 60;
                default: bias = 92;
            endcase
            for (int i = 0; i < 100; i++) begin
                rst = ($urandom_range(0, 999) < 3);
                cyc($urandom_range(0, 99) < bias,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 30);
            end
        end
        rst = 1'b0;
        repeat (3) cyc(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tmr_err_monitor
